// File: rtl/cla_pkg.sv
// Shared types, widths and the golden adder function for the carry-lookahead adder family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } cla_state_e;

   // Default operand width and the matching {cin, b, a} vector-index width.
   localparam int CLA_N  = 3;
   localparam int CLA_VW = 2 * CLA_N + 1;

   // Full-width reference sum: never truncated, so the carry-out is kept.
   function automatic logic [CLA_N:0] golden_sum(
      input logic [CLA_N-1:0] a,
      input logic [CLA_N-1:0] b,
      input logic             cin
   );
      return {1'b0, a} + {1'b0, b} + {{CLA_N{1'b0}}, cin};
   endfunction

endpackage

// File: rtl/cla_exp_pipe.sv
// Delay line carrying {valid, payload} so expected results line up with the adder's latency.
// Latency: DEPTH cycles (DEPTH=0 is a combinational pass-through).
// Backpressure: none; one entry advances every cycle.
// Ports: clk, rst (sync, active-high, clears all valid bits), in_vld/in_dat -> out_vld/out_dat.
module cla_exp_pipe
   import cla_pkg::*;
#(
   parameter int DEPTH = 0,
   parameter int W     = CLA_VW + CLA_N + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   output logic [W-1:0] out_dat
);

   if (DEPTH == 0) begin : g_pass
      // No storage, so clock and reset are deliberately unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_vld        = in_vld;
      assign out_dat        = in_dat;
   end else begin : g_pipe
      logic [DEPTH-1:0]        vld_q, vld_d;
      logic [DEPTH-1:0][W-1:0] dat_q, dat_d;

      always_comb begin
         vld_d    = vld_q;
         dat_d    = dat_q;
         vld_d[0] = in_vld;
         dat_d[0] = in_dat;
         for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
         end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
         end
      end

      assign out_vld = vld_q[DEPTH-1];
      assign out_dat = dat_q[DEPTH-1];
   end

endmodule

// File: rtl/cla_bist.sv
// Built-in self-test for one adder: sweeps every {cin,b,a} vector, checks S against a+b+cin.
// Latency: done rises 2^(2N+1)+LAT+1 edges after the edge that samples start.
// Backpressure: none; one vector per cycle, start is ignored while busy.
// Ports: clk, rst (sync, active-high), start; op_a/op_b/op_cin to the adder, dut_s back;
//        busy, done, pass, err_cnt, first_fail, first_fail_vld report the sweep outcome.
module cla_bist
   import cla_pkg::*;
#(
   parameter int N   = CLA_N,
   parameter int LAT = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic [N-1:0]   op_a,
   output logic [N-1:0]   op_b,
   output logic           op_cin,
   input  logic [N:0]     dut_s,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [2*N+1:0] err_cnt,
   output logic [2*N:0]   first_fail,
   output logic           first_fail_vld
);

   localparam int VW = 2 * N + 1;       // vector index {cin, b, a}
   localparam int EW = 2 * N + 2;       // error counter, holds 2^VW without wrapping
   localparam int PW = VW + N + 1;      // delay-line payload {index, expected sum}
   localparam logic [VW-1:0] V_LAST     = '1;
   localparam logic [2:0]    DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

   cla_state_e    state_q, state_d;
   logic [VW-1:0] op_q, op_d;
   logic          op_vld_q, op_vld_d;
   logic [2:0]    drain_cnt_q, drain_cnt_d;
   logic [EW-1:0] err_cnt_q, err_cnt_d;
   logic [VW-1:0] first_fail_q, first_fail_d;
   logic          first_fail_vld_q, first_fail_vld_d;

   logic          last_on_op;
   logic [N:0]    exp_sum;
   logic          chk_vld;
   logic [PW-1:0] chk_dat;
   logic [VW-1:0] chk_idx;
   logic [N:0]    chk_exp;
   logic          mismatch;

   // The final vector is on the adder inputs this cycle.
   assign last_on_op = op_vld_q && (op_q == V_LAST);

   assign exp_sum = (N+1)'(op_q[N-1:0]) + (N+1)'(op_q[2*N-1:N]) + (N+1)'(op_q[VW-1]);

   cla_exp_pipe #(
      .DEPTH (LAT),
      .W     (PW)
   ) u_exp_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (op_vld_q),
      .in_dat  ({op_q, exp_sum}),
      .out_vld (chk_vld),
      .out_dat (chk_dat)
   );

   assign chk_idx  = chk_dat[PW-1:N+1];
   assign chk_exp  = chk_dat[N:0];
   assign mismatch = chk_vld && (dut_s != chk_exp);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         op_q             <= '0;
         op_vld_q         <= 1'b0;
         drain_cnt_q      <= '0;
         err_cnt_q        <= '0;
         first_fail_q     <= '0;
         first_fail_vld_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         op_vld_q         <= op_vld_d;
         drain_cnt_q      <= drain_cnt_d;
         err_cnt_q        <= err_cnt_d;
         first_fail_q     <= first_fail_d;
         first_fail_vld_q <= first_fail_vld_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = RUN;
         RUN:        if (last_on_op) state_d = (LAT == 0) ? DONE : DRAIN;
         DRAIN:      if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // Vector generation and result checking
   always_comb begin
      op_d             = op_q;
      op_vld_d         = 1'b0;
      drain_cnt_d      = '0;
      err_cnt_d        = err_cnt_q;
      first_fail_d     = first_fail_q;
      first_fail_vld_d = first_fail_vld_q;

      case (state_q)
         IDLE: op_d = '0;
         RUN: begin
            // The first RUN cycle has nothing valid on op_q yet, so it issues vector 0;
            // afterwards each cycle issues the successor of the vector on the inputs.
            if (!last_on_op) begin
               op_vld_d = 1'b1;
               op_d     = op_vld_q ? op_q + VW'(1) : '0;
            end
         end
         DRAIN:   drain_cnt_d = drain_cnt_q + 3'd1;
         default: ;
      endcase

      if (mismatch) begin
         err_cnt_d = err_cnt_q + EW'(1);
         if (!first_fail_vld_q) begin
            first_fail_d     = chk_idx;
            first_fail_vld_d = 1'b1;
         end
      end

      // A new sweep clears the previous result; the delay line is empty in IDLE/DONE.
      if (((state_q == IDLE) || (state_q == DONE)) && start) begin
         err_cnt_d        = '0;
         first_fail_d     = '0;
         first_fail_vld_d = 1'b0;
      end
   end

   // Outputs
   always_comb begin
      op_a           = op_q[N-1:0];
      op_b           = op_q[2*N-1:N];
      op_cin         = op_q[VW-1];
      busy           = (state_q == RUN) || (state_q == DRAIN);
      done           = (state_q == DONE);
      pass           = done && (err_cnt_q == '0);
      err_cnt        = err_cnt_q;
      first_fail     = first_fail_q;
      first_fail_vld = first_fail_vld_q;
   end

endmodule
